// File: rtl/l2_line_adaptor.sv
// Adapts one L2 line transfer to a sequence of memory bursts: fills gather
// read beats into a line buffer, writebacks stream the buffered line out beat by beat.
module l2_line_adaptor #(
   parameter int s_offset = 5,
   parameter int s_burst  = 64,
   parameter int s_addr   = 32,
   localparam int s_line  = 8 * (2 ** s_offset)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [s_line-1:0]  line_i,
   output logic [s_line-1:0]  line_o,
   input  logic [s_addr-1:0]  address_i,
   input  logic              read_i,
   input  logic              write_i,
   output logic              resp_o,
   input  logic [s_burst-1:0] burst_i,
   output logic [s_burst-1:0] burst_o,
   output logic [s_addr-1:0]  address_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
);

   localparam int beats = s_line / s_burst;
   localparam int cnt_w = $clog2(beats);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   typedef logic [cnt_w-1:0] cnt_t;

   state_t              state, state_next;
   cnt_t                cnt;
   logic [s_line-1:0]   buffer;
   logic [s_addr-1:0]   addr;
   logic                last_beat;

   assign last_beat = resp_i && (cnt == cnt_t'(beats - 1));

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         // NOTE: the line buffer is cleared on reset because line_o is
         // observable from it directly; a flop-based buffer makes this cheap.
         buffer <= '0;
         addr   <= '0;
      end else begin
         state <= state_next;
         unique case (state)
            IDLE: begin
               if (write_i || read_i) begin
                  addr <= {address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
                  cnt  <= '0;
               end
               if (write_i) buffer <= line_i;
            end
            RD: begin
               if (resp_i) begin
                  buffer[s_burst*int'(cnt) +: s_burst] <= burst_i;
                  cnt <= cnt + cnt_t'(1);
               end
            end
            WR: begin
               if (resp_i) cnt <= cnt + cnt_t'(1);
            end
            DONE: ;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      read_o     = 1'b0;
      write_o    = 1'b0;
      resp_o     = 1'b0;
      burst_o    = '0;
      unique case (state)
         IDLE: begin
            // Writeback wins when both requests arrive together.
            if (write_i)     state_next = WR;
            else if (read_i) state_next = RD;
         end
         RD: begin
            read_o = 1'b1;
            if (last_beat) state_next = DONE;
         end
         WR: begin
            write_o = 1'b1;
            burst_o = buffer[s_burst*int'(cnt) +: s_burst];
            if (last_beat) state_next = DONE;
         end
         DONE: begin
            resp_o     = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   assign line_o    = buffer;
   assign address_o = addr;

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Bench for l2_line_adaptor: cycle tables for fill/writeback, hand-written
// corner sequences, then random transactions against a transaction-level model.
module tb_l2_line_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o;
   logic [63:0]  burst_i, burst_o;
   logic         read_o, write_o, resp_i;

   int errors = 0;
   int checks = 0;

   l2_line_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rd, wr, rsp;
      logic [31:0]  addr;
      logic [255:0] line;
      logic [63:0]  bi;
      logic         e_rd, e_wr, e_resp;
      bit           chk_bo;
      logic [63:0]  e_bo;
      bit           chk_addr;
      logic [31:0]  e_addr;
      bit           chk_line;
      logic [255:0] e_line;
   } vec_t;

   vec_t vecs[$];

   localparam logic [255:0] fill_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] wb_line   = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
   localparam logic [255:0] line_55   = {32{8'h55}};

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic rd, wr, rsp, input logic [31:0] addr,
                               input logic [255:0] line, input logic [63:0] bi,
                               input logic e_rd, e_wr, e_resp,
                               input bit chk_bo, input logic [63:0] e_bo,
                               input bit chk_addr, input logic [31:0] e_addr,
                               input bit chk_line, input logic [255:0] e_line);
      vec_t v;
      v.rd = rd; v.wr = wr; v.rsp = rsp; v.addr = addr; v.line = line; v.bi = bi;
      v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp;
      v.chk_bo = chk_bo; v.e_bo = e_bo;
      v.chk_addr = chk_addr; v.e_addr = e_addr;
      v.chk_line = chk_line; v.e_line = e_line;
      return v;
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   task automatic idle_inputs();
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      burst_i = '0; line_i = '0; address_i = '0;
   endtask

   // Runs a fill of four back-to-back beats from IDLE and leaves the DUT in DONE.
   task automatic gapless_fill(input logic [31:0] addr, input logic [63:0] beat);
      read_i = 1'b1; address_i = addr; resp_i = 1'b0;
      step();
      read_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         resp_i = 1'b1; burst_i = beat;
         step();
      end
      resp_i = 1'b0;
   endtask

   initial begin
      // Fill, no gaps: rows 0..6
      vecs.push_back(mk(1,0,0, 32'h0000_1234, '0, '0,  0,0,0, 0,'0, 0,'0, 0,'0));
      vecs.push_back(mk(0,0,1, '0, '0, 64'h1111_1111_1111_1111, 1,0,0, 0,'0, 1,32'h0000_1220, 0,'0));
      vecs.push_back(mk(0,0,1, '0, '0, 64'h2222_2222_2222_2222, 1,0,0, 0,'0, 1,32'h0000_1220, 0,'0));
      vecs.push_back(mk(0,0,1, '0, '0, 64'h3333_3333_3333_3333, 1,0,0, 0,'0, 1,32'h0000_1220, 0,'0));
      vecs.push_back(mk(0,0,1, '0, '0, 64'h4444_4444_4444_4444, 1,0,0, 0,'0, 1,32'h0000_1220, 0,'0));
      vecs.push_back(mk(0,0,0, '0, '0, '0, 0,0,1, 0,'0, 1,32'h0000_1220, 1,fill_line));
      vecs.push_back(mk(0,0,1, '0, '0, 64'hFFFF, 0,0,0, 0,'0, 0,'0, 1,fill_line));
      // Writeback with gaps 1,0,0,1,1,0,1; a stray read_i mid-burst must be ignored
      vecs.push_back(mk(0,1,0, 32'h0000_ABCD, wb_line, '0, 0,0,0, 0,'0, 0,'0, 0,'0));
      vecs.push_back(mk(0,0,1, '0, '0, '0, 0,1,0, 1,64'hAAAA_AAAA_AAAA_AAAA, 1,32'h0000_ABC0, 0,'0));
      vecs.push_back(mk(0,0,0, '0, '0, '0, 0,1,0, 1,64'hBBBB_BBBB_BBBB_BBBB, 1,32'h0000_ABC0, 0,'0));
      vecs.push_back(mk(1,0,0, 32'hFFFF_FFFF, '0, '0, 0,1,0, 1,64'hBBBB_BBBB_BBBB_BBBB, 1,32'h0000_ABC0, 0,'0));
      vecs.push_back(mk(0,0,1, '0, '0, '0, 0,1,0, 1,64'hBBBB_BBBB_BBBB_BBBB, 1,32'h0000_ABC0, 0,'0));
      vecs.push_back(mk(0,0,1, '0, '0, '0, 0,1,0, 1,64'hCCCC_CCCC_CCCC_CCCC, 1,32'h0000_ABC0, 0,'0));
      vecs.push_back(mk(0,0,0, '0, '0, '0, 0,1,0, 1,64'hDDDD_DDDD_DDDD_DDDD, 1,32'h0000_ABC0, 0,'0));
      vecs.push_back(mk(0,0,1, '0, '0, '0, 0,1,0, 1,64'hDDDD_DDDD_DDDD_DDDD, 1,32'h0000_ABC0, 0,'0));
      vecs.push_back(mk(0,0,0, '0, '0, '0, 0,0,1, 0,'0, 1,32'h0000_ABC0, 1,wb_line));
      vecs.push_back(mk(0,0,0, '0, '0, '0, 0,0,0, 0,'0, 0,'0, 0,'0));

      // Reset state
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      check("reset read_o", read_o, 1'b0);
      check("reset write_o", write_o, 1'b0);
      check("reset resp_o", resp_o, 1'b0);
      check("reset line_o", line_o, '0);
      check("reset burst_o", burst_o, '0);
      check("reset address_o", address_o, '0);
      rst = 1'b0;
      step();

      // Cycle tables
      foreach (vecs[i]) begin
         read_i = vecs[i].rd; write_i = vecs[i].wr; resp_i = vecs[i].rsp;
         address_i = vecs[i].addr; line_i = vecs[i].line; burst_i = vecs[i].bi;
         check($sformatf("vec%0d read_o", i), read_o, vecs[i].e_rd);
         check($sformatf("vec%0d write_o", i), write_o, vecs[i].e_wr);
         check($sformatf("vec%0d resp_o", i), resp_o, vecs[i].e_resp);
         if (vecs[i].chk_bo)   check($sformatf("vec%0d burst_o", i), burst_o, vecs[i].e_bo);
         if (vecs[i].chk_addr) check($sformatf("vec%0d address_o", i), address_o, vecs[i].e_addr);
         if (vecs[i].chk_line) check($sformatf("vec%0d line_o", i), line_o, vecs[i].e_line);
         step();
      end
      idle_inputs();

      // Simultaneous request: writeback wins
      read_i = 1'b1; write_i = 1'b1; line_i = wb_line; address_i = 32'h40;
      step();
      read_i = 1'b0; write_i = 1'b0;
      check("simul write_o", write_o, 1'b1);
      check("simul read_o", read_o, 1'b0);
      check("simul burst_o", burst_o, 64'hAAAA_AAAA_AAAA_AAAA);
      for (int k = 0; k < 4; k++) begin
         resp_i = 1'b1;
         step();
      end
      resp_i = 1'b0;
      check("simul resp_o", resp_o, 1'b1);
      step();

      // Held request: read_i high through resp_o, dropped the cycle after
      begin
         int n_resp = 0;
         int n_rd = 0;
         read_i = 1'b1; address_i = 32'h0000_2000; resp_i = 1'b1; burst_i = 64'h1;
         for (int c = 0; c < 12; c++) begin
            if (resp_o) n_resp++;
            if (read_o) n_rd++;
            step();
            if (resp_o) begin
               n_resp++;
               step();
               read_i = 1'b0;
               resp_i = 1'b0;
            end
         end
         check("held resp_o pulses", n_resp, 1);
         check("held read_o cycles", n_rd, 4);
      end
      idle_inputs();
      step();

      // Reset mid-fill after two beats
      read_i = 1'b1; address_i = 32'h0000_0100;
      step();
      read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h0123_4567_89AB_CDEF;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; resp_i = 1'b0;
      check("abort read_o", read_o, 1'b0);
      check("abort line_o", line_o, '0);
      begin
         int n_resp = 0;
         for (int c = 0; c < 4; c++) begin
            if (resp_o || read_o) n_resp++;
            step();
         end
         check("abort no activity", n_resp, 0);
      end
      gapless_fill(32'h0000_0300, 64'h5555_5555_5555_5555);
      check("refill resp_o", resp_o, 1'b1);
      check("refill line_o", line_o, line_55);
      step();

      // Idle noise on resp_i/burst_i
      begin
         int bad = 0;
         for (int c = 0; c < 8; c++) begin
            resp_i = c[0]; burst_i = {$urandom, $urandom};
            if (resp_o || read_o || write_o || line_o !== line_55) bad++;
            step();
         end
         check("idle noise", bad, 0);
      end
      idle_inputs();
      step();

      // Random transactions against a transaction-level model
      for (int t = 0; t < 40; t++) begin
         bit           do_wr;
         logic [255:0] line;
         logic [31:0]  addr, exp_addr;
         logic [63:0]  beats[$];
         logic [63:0]  words[4];
         logic [255:0] exp_line;
         int           cyc;
         do_wr = $urandom_range(0, 1);
         line = rand_line();
         addr = $urandom;
         exp_addr = {addr[31:5], 5'b0};
         for (int k = 0; k < 4; k++) words[k] = line[64*k +: 64];
         beats.delete();
         write_i = do_wr;
         read_i = do_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
         line_i = line; address_i = addr; resp_i = $urandom_range(0, 1);
         step();
         cyc = 0;
         while (beats.size() < 4 && cyc < 64) begin
            resp_i = ($urandom_range(0, 2) != 0);
            burst_i = {$urandom, $urandom};
            read_i = $urandom_range(0, 1); write_i = $urandom_range(0, 1);
            address_i = $urandom; line_i = rand_line();
            check($sformatf("rand%0d read_o", t), read_o, !do_wr);
            check($sformatf("rand%0d write_o", t), write_o, do_wr);
            check($sformatf("rand%0d early resp_o", t), resp_o, 1'b0);
            check($sformatf("rand%0d address_o", t), address_o, exp_addr);
            if (do_wr) check($sformatf("rand%0d burst_o", t), burst_o, words[beats.size()]);
            if (resp_i) beats.push_back(do_wr ? words[beats.size()] : burst_i);
            step();
            cyc++;
         end
         exp_line = do_wr ? line : {beats[3], beats[2], beats[1], beats[0]};
         read_i = 1'b0; write_i = 1'b0; resp_i = $urandom_range(0, 1);
         check($sformatf("rand%0d resp_o", t), resp_o, 1'b1);
         check($sformatf("rand%0d done idle bus", t), {read_o, write_o}, 2'b00);
         check($sformatf("rand%0d line_o", t), line_o, exp_line);
         check($sformatf("rand%0d done address_o", t), address_o, exp_addr);
         step();
         check($sformatf("rand%0d resp_o single", t), resp_o, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l2_line_adaptor.md
Name: l2_line_adaptor

Overview:
- Sits between the L2 controller/data array and physical memory.
- Converts one 256-bit L2 line transfer into four 64-bit memory bursts.
- Fill path: collects four read beats from memory into a complete line. The L2 controller writes this line into the data array with an all-ones byte-enable mask.
- Writeback path: splits a dirty line read out of the data array into four write beats.

Parameters:
- s_offset, 5, line offset bits; line width = 8*2**s_offset = 256.
- s_burst, 64, memory beat width in bits; beats per line = line width / s_burst = 4.
- s_addr, 32, address width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- line_i  input  256  writeback line from data array
- line_o  output  256  assembled fill line
- address_i  input  32  L2 request address
- read_i  input  1  fill request
- write_i  input  1  writeback request
- resp_o  output  1  one-cycle completion pulse
- burst_i  input  64  memory read beat
- burst_o  output  64  memory write beat
- address_o  output  32  line-aligned memory address
- read_o  output  1  memory read request
- write_o  output  1  memory write request
- resp_i  input  1  memory beat-accept/valid strobe

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, beat counter=0.
  - read_o=0, write_o=0, resp_o=0.
  - line_o=0, burst_o=0, address_o=0.
  - Reset mid-burst abandons the transfer with no resp_o, and read_o/write_o drop the next cycle.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - write_i=1: latch line_i into the internal line buffer and address_o={address_i[31:5],5'b0}, counter=0, go to WR.
  - Else read_i=1: latch address_o the same way, counter=0, go to RD.
  - Write has priority when read_i and write_i are both high.
  - resp_i is ignored in IDLE.
- RD:
  - read_o=1 combinationally while in RD.
  - Each cycle with resp_i=1: buffer[64*cnt +: 64] <= burst_i, cnt++.
  - resp_i=0 cycles (gaps) stall with no change.
  - On the beat with cnt==3: go to DONE.
- WR:
  - write_o=1.
  - burst_o = buffer[64*cnt +: 64], combinational from the counter.
  - Each resp_i=1 advances cnt. Gaps hold the current beat.
  - On cnt==3 with resp_i: go to DONE.
- DONE:
  - resp_o=1 for exactly this cycle; read_o=write_o=0.
  - line_o = buffer, and is valid in this cycle.
  - Unconditionally go to IDLE next cycle.
  - Requests are ignored in DONE, so a request held through the resp_o cycle is not double-issued.
  - The requester must drop read_i/write_i in the cycle after resp_o; a request still high in IDLE starts a new transaction.
- line_o: driven from the buffer at all times. After a fill it holds its value until the next fill or writeback overwrites the buffer.
- Counter: 2 bits, wraps 3->0 on the last beat. The counter is 0 on entry to RD/WR.
- address_o is stable for the whole RD/WR/DONE window.
- Latency: with no memory gaps, request in IDLE cycle T gives read_o/write_o in T+1..T+4 and resp_o in T+5.
- Changes to read_i/write_i/address_i/line_i while busy have no effect.

Test Plan:
- Fill, no gaps:
  - Stimulus: read_i with address_i=0x0000_1234; resp_i high for 4 cycles; burst_i=0x1111..11, 0x2222..22, 0x3333..33, 0x4444..44.
  - Required: address_o=0x0000_1220; read_o high exactly 4 cycles; resp_o one pulse; line_o={0x44..,0x33..,0x22..,0x11..}.
- Writeback with gaps:
  - Stimulus: write_i with line_i=0xDDDD..CCCC..BBBB..AAAA (64-bit words); resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o=0xAAAA.. held through the first accept, then BB.. held through the gaps, then CC.., then DD..; write_o high 7 cycles; resp_o the cycle after the last accept.
- Simultaneous request:
  - Stimulus: read_i=write_i=1 in IDLE.
  - Required: write_o asserted, read_o stays 0.
- Held request:
  - Stimulus: read_i held through the resp_o cycle, dropped the cycle after.
  - Required: exactly one transaction and one resp_o pulse.
- Reset mid-operation:
  - Stimulus: rst asserted after 2 of 4 read beats, then a new fill with burst_i=0x5555..55 repeated.
  - Required: read_o=0 and resp_o never pulses for the aborted fill; the new fill gives line_o all 0x55 bytes.
- Idle noise:
  - Stimulus: resp_i toggled in IDLE.
  - Required: counter stays 0, line_o unchanged, no resp_o.
